calc_entry_seq: RTL and testbench
=================================

# calc_entry_seq

Operand/operator entry sequencer that sits directly upstream of the 4-bit combinational calculator. It turns push-button level inputs (hex digit, operator, equals, clear) into the calculator's 14-bit command word, {op[1:0], A[3:0], B[3:0], 4'b0000}. It presents that word through a valid/ready handshake. It also captures the calculator's returned result so that operations can be chained.

## Interface
- No parameters; all widths are fixed by the 14-bit command-word format.
- clk  input  1  single system clock; all logic is on its rising edge.
- rst_n  input  1  reset: synchronous, active-low.
- digit_btn  input  1  digit button level; a rising edge enters the value on digit_val.
- digit_val  input  4  hex digit value, sampled on the digit_btn rising edge.
- op_btn  input  1  operator button level; a rising edge latches op_val.
- op_val  input  2  operator: 00 add, 01 sub, 10 or, 11 negate (unary).
- eq_btn  input  1  equals button level.
- clr_btn  input  1  clear button level.
- cmd_ready  input  1  downstream accepts cmd_word on any edge where cmd_valid is also high.
- result_in  input  4  calculator result for the current cmd_word; captured on transfer.
- cmd_word  output  14  {op, A, B, 4'b0000}; reset value 14'h0000.
- cmd_valid  output  1  command pending; reset value 0.
- state  output  2  current FSM state, for the GUI; reset value 00.
- err  output  1  one-cycle pulse on an illegal key; reset value 0.
- cmd_count  output  8  number of completed transfers, wraps at 255 to 0; reset value 0.

## Operation
- Edge detection:
  - Each button is registered once; an event is btn && !btn_q.
  - Button inputs are already synchronous to clk.
  - A held button produces exactly one event.
- Event priority within one cycle: clr > eq > op > digit. Only the highest-priority event acts; lower-priority events that cycle are dropped silently (no err).
- Internal registers: A, B (4b), op (2b), a_has, b_has flags, last_result (4b).
- S_A (00), entering A:
  - digit: A=digit_val, a_has=1.
  - op with a_has=1, op_val != 11: op latched, b_has=0, go to S_B.
  - op with a_has=1, op_val = 11: op latched, B=0, go to S_ISSUE.
  - op with a_has=0: err pulse.
  - eq: err pulse.
- S_B (01), entering B:
  - digit: B=digit_val, b_has=1.
  - op != 11: op overwritten, stay in S_B.
  - op = 11: op=11, B=0, go to S_ISSUE.
  - eq with b_has=1: go to S_ISSUE.
  - eq with b_has=0: err pulse.
- S_ISSUE (10):
  - cmd_valid=1.
  - cmd_word is held stable.
  - digit, op and eq events give an err pulse and change nothing.
  - cmd_valid && cmd_ready: last_result=result_in, cmd_count+1, go to S_DONE.
- S_DONE (11):
  - cmd_word is held and shows the last command.
  - digit: A=digit_val, a_has=1, B=0, b_has=0, op=00, go to S_A.
  - op: A=last_result, a_has=1, op latched. Then go to S_B (b_has=0), or to S_ISSUE with B=0 if op_val = 11.
  - eq: err pulse.
- cmd_word always reflects {op, A, B, 4'b0000} and updates the cycle after any register change. Its low nibble is always 0000.
- clr from any state, and rst_n=0, are identical in effect:
  - A=B=op=0, flags and last_result=0, cmd_valid=0, state S_A.
  - cmd_count is preserved on clr and cleared only by rst_n.
- clr in S_ISSUE withdraws cmd_valid without a transfer.

## Timing
- Event-to-register latency is 0 extra cycles: the register updates on the same edge that first samples btn=1 with btn_q=0, and outputs change after that edge.
- cmd_valid rises the cycle after the eq/op edge that enters S_ISSUE.
- cmd_valid stays high until the first edge where cmd_ready=1. It falls after that edge, and cmd_count increments on that edge.
- A single-cycle transfer is legal when cmd_ready is already high.
- cmd_ready while cmd_valid=0 is ignored.
- result_in is sampled only on the transfer edge.
- err is high for exactly one cycle per illegal event.
- rst_n is sampled only on clk rising edges. Asserting it mid-handshake drops the pending command; no transfer is counted.
- clr and rst_n win over a simultaneous cmd_ready: no transfer and no count.

## Test plan
- Add: digit 3, op 00, digit 4, eq, cmd_ready=1 one cycle later, result_in=7.
  - cmd_word=14'b00_0011_0100_0000 and cmd_valid=1 for 2 cycles.
  - cmd_count=1, state=11, last_result=7.
- Chain: after the add above, op 01, digit 2, eq.
  - cmd_word=14'b01_0111_0010_0000, because A is taken from result 7.
- Unary negate: digit 5, op 11.
  - S_ISSUE directly, cmd_word=14'b11_0101_0000_0000, cmd_valid=1 the next cycle.
- Illegal keys: eq in S_A; op with no digit; digit in S_ISSUE.
  - Each gives exactly one err pulse; state and cmd_word are unchanged.
- Backpressure and clear:
  - Hold cmd_ready=0 for 10 cycles in S_ISSUE: cmd_word is stable and cmd_valid stays high.
  - Then clr together with cmd_ready=1: cmd_valid=0, state=00, cmd_count unchanged.
- Priority, held buttons and reset:
  - Simultaneous digit/op/eq edges in S_B with b_has=1: only eq acts.
  - A button held high for 20 cycles gives a single event.
  - rst_n=0 mid-entry: all outputs return to their reset values, including cmd_count=0.

Source files
------------

// File: rtl/calc_entry_seq.sv
`default_nettype none
// ============================================================================
// Module      : calc_entry_seq
// Description : Push-button operand/operator entry sequencer that builds the
//               14-bit calculator command word and hands it off via valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module calc_entry_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        digit_btn,
    input  logic [3:0]  digit_val,
    input  logic        op_btn,
    input  logic [1:0]  op_val,
    input  logic        eq_btn,
    input  logic        clr_btn,
    input  logic        cmd_ready,
    input  logic [3:0]  result_in,
    output logic [13:0] cmd_word,
    output logic        cmd_valid,
    output logic [1:0]  state,
    output logic        err,
    output logic [7:0]  cmd_count
);

    typedef enum logic [1:0] {
        S_A     = 2'b00,
        S_B     = 2'b01,
        S_ISSUE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    localparam logic [1:0] c_OP_NEG = 2'b11;

    state_t      r_state, w_state_nx;
    logic [3:0]  r_a, w_a_nx;
    logic [3:0]  r_b, w_b_nx;
    logic [1:0]  r_op, w_op_nx;
    logic        r_a_has, w_a_has_nx;
    logic        r_b_has, w_b_has_nx;
    logic [3:0]  r_last, w_last_nx;
    logic        r_err, w_err_nx;
    logic [7:0]  r_count, w_count_nx;

    logic        r_digit_q, r_op_q, r_eq_q, r_clr_q;
    logic        w_digit_ev, w_op_ev, w_eq_ev, w_clr_ev;

    assign w_digit_ev = digit_btn & ~r_digit_q;
    assign w_op_ev    = op_btn    & ~r_op_q;
    assign w_eq_ev    = eq_btn    & ~r_eq_q;
    assign w_clr_ev   = clr_btn   & ~r_clr_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_A;
            r_a       <= 4'd0;
            r_b       <= 4'd0;
            r_op      <= 2'd0;
            r_a_has   <= 1'b0;
            r_b_has   <= 1'b0;
            r_last    <= 4'd0;
            r_err     <= 1'b0;
            r_count   <= 8'd0;
            r_digit_q <= 1'b0;
            r_op_q    <= 1'b0;
            r_eq_q    <= 1'b0;
            r_clr_q   <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_a       <= w_a_nx;
            r_b       <= w_b_nx;
            r_op      <= w_op_nx;
            r_a_has   <= w_a_has_nx;
            r_b_has   <= w_b_has_nx;
            r_last    <= w_last_nx;
            r_err     <= w_err_nx;
            r_count   <= w_count_nx;
            r_digit_q <= digit_btn;
            r_op_q    <= op_btn;
            r_eq_q    <= eq_btn;
            r_clr_q   <= clr_btn;
        end
    end

    // The if/else ordering inside each state implements eq > op > digit.
    always_comb begin
        w_state_nx = r_state;
        w_a_nx     = r_a;
        w_b_nx     = r_b;
        w_op_nx    = r_op;
        w_a_has_nx = r_a_has;
        w_b_has_nx = r_b_has;
        w_last_nx  = r_last;
        w_err_nx   = 1'b0;
        w_count_nx = r_count;

        if (w_clr_ev) begin
            w_state_nx = S_A;
            w_a_nx     = 4'd0;
            w_b_nx     = 4'd0;
            w_op_nx    = 2'd0;
            w_a_has_nx = 1'b0;
            w_b_has_nx = 1'b0;
            w_last_nx  = 4'd0;
        end else begin
            case (r_state)
                S_A: begin
                    if (w_eq_ev) begin
                        w_err_nx = 1'b1;
                    end else if (w_op_ev) begin
                        if (!r_a_has) begin
                            w_err_nx = 1'b1;
                        end else begin
                            w_op_nx = op_val;
                            if (op_val == c_OP_NEG) begin
                                w_b_nx     = 4'd0;
                                w_state_nx = S_ISSUE;
                            end else begin
                                w_b_has_nx = 1'b0;
                                w_state_nx = S_B;
                            end
                        end
                    end else if (w_digit_ev) begin
                        w_a_nx     = digit_val;
                        w_a_has_nx = 1'b1;
                    end
                end
                S_B: begin
                    if (w_eq_ev) begin
                        if (r_b_has) w_state_nx = S_ISSUE;
                        else         w_err_nx   = 1'b1;
                    end else if (w_op_ev) begin
                        w_op_nx = op_val;
                        if (op_val == c_OP_NEG) begin
                            w_b_nx     = 4'd0;
                            w_state_nx = S_ISSUE;
                        end
                    end else if (w_digit_ev) begin
                        w_b_nx     = digit_val;
                        w_b_has_nx = 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (w_eq_ev || w_op_ev || w_digit_ev) begin
                        w_err_nx = 1'b1;
                    end
                    if (cmd_ready) begin
                        w_last_nx  = result_in;
                        w_count_nx = r_count + 8'd1;
                        w_state_nx = S_DONE;
                    end
                end
                default: begin
                    // S_DONE: an operator chains off the previous result.
                    if (w_eq_ev) begin
                        w_err_nx = 1'b1;
                    end else if (w_op_ev) begin
                        w_a_nx     = r_last;
                        w_a_has_nx = 1'b1;
                        w_op_nx    = op_val;
                        if (op_val == c_OP_NEG) begin
                            w_b_nx     = 4'd0;
                            w_state_nx = S_ISSUE;
                        end else begin
                            w_b_has_nx = 1'b0;
                            w_state_nx = S_B;
                        end
                    end else if (w_digit_ev) begin
                        w_a_nx     = digit_val;
                        w_a_has_nx = 1'b1;
                        w_b_nx     = 4'd0;
                        w_b_has_nx = 1'b0;
                        w_op_nx    = 2'd0;
                        w_state_nx = S_A;
                    end
                end
            endcase
        end
    end

    assign cmd_word  = {r_op, r_a, r_b, 4'b0000};
    assign cmd_valid = (r_state == S_ISSUE);
    assign state     = r_state;
    assign err       = r_err;
    assign cmd_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_calc_entry_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_calc_entry_seq
// Description : Self-checking bench for calc_entry_seq against a key-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_calc_entry_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        digit_btn, op_btn, eq_btn, clr_btn, cmd_ready;
    logic [3:0]  digit_val, result_in;
    logic [1:0]  op_val;
    logic [13:0] cmd_word;
    logic        cmd_valid, err;
    logic [1:0]  state;
    logic [7:0]  cmd_count;

    int n_cmp = 0;
    int n_bad = 0;

    localparam int c_P_A = 0, c_P_B = 1, c_P_ISSUE = 2, c_P_DONE = 3;
    localparam int c_K_NONE = 0, c_K_DIGIT = 1, c_K_OP = 2, c_K_EQ = 3, c_K_CLR = 4;

    // Model state: what the calculator user has typed so far.
    int         m_phase;
    bit [3:0]   m_a, m_b, m_last;
    bit [1:0]   m_op;
    bit         m_a_has, m_b_has, m_err;
    bit [7:0]   m_count;
    bit         p_dig, p_op, p_eq, p_clr;

    calc_entry_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .digit_btn (digit_btn),
        .digit_val (digit_val),
        .op_btn    (op_btn),
        .op_val    (op_val),
        .eq_btn    (eq_btn),
        .clr_btn   (clr_btn),
        .cmd_ready (cmd_ready),
        .result_in (result_in),
        .cmd_word  (cmd_word),
        .cmd_valid (cmd_valid),
        .state     (state),
        .err       (err),
        .cmd_count (cmd_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit [13:0] m_word();
        return {m_op, m_a, m_b, 4'b0000};
    endfunction

    task automatic m_clear(input bit full);
        m_phase = c_P_A; m_a = 0; m_b = 0; m_op = 0;
        m_a_has = 0; m_b_has = 0; m_last = 0;
        if (full) begin
            m_count = 0; p_dig = 0; p_op = 0; p_eq = 0; p_clr = 0;
        end
    endtask

    // Operator key (also used when chaining from a finished result).
    task automatic m_take_op(input bit [1:0] o);
        m_op = o;
        if (o == 2'b11) begin m_b = 0; m_phase = c_P_ISSUE; end
        else begin m_b_has = 0; m_phase = c_P_B; end
    endtask

    task automatic model_step();
        int key;
        m_err = 0;
        if (!rst_n) begin m_clear(1); return; end
        key = c_K_NONE;
        if (digit_btn && !p_dig) key = c_K_DIGIT;
        if (op_btn && !p_op)     key = c_K_OP;
        if (eq_btn && !p_eq)     key = c_K_EQ;
        if (clr_btn && !p_clr)   key = c_K_CLR;
        p_dig = digit_btn; p_op = op_btn; p_eq = eq_btn; p_clr = clr_btn;
        if (key == c_K_CLR) begin m_clear(0); return; end
        case (m_phase)
            c_P_A: begin
                if (key == c_K_EQ || (key == c_K_OP && !m_a_has)) m_err = 1;
                else if (key == c_K_OP) m_take_op(op_val);
                else if (key == c_K_DIGIT) begin m_a = digit_val; m_a_has = 1; end
            end
            c_P_B: begin
                if (key == c_K_EQ) begin
                    if (m_b_has) m_phase = c_P_ISSUE; else m_err = 1;
                end else if (key == c_K_OP) begin
                    m_op = op_val;
                    if (op_val == 2'b11) begin m_b = 0; m_phase = c_P_ISSUE; end
                end else if (key == c_K_DIGIT) begin m_b = digit_val; m_b_has = 1; end
            end
            c_P_ISSUE: begin
                m_err = (key != c_K_NONE);
                if (cmd_ready) begin
                    m_last = result_in; m_count = m_count + 1; m_phase = c_P_DONE;
                end
            end
            default: begin
                if (key == c_K_EQ) m_err = 1;
                else if (key == c_K_OP) begin m_a = m_last; m_a_has = 1; m_take_op(op_val); end
                else if (key == c_K_DIGIT) begin
                    m_a = digit_val; m_a_has = 1; m_b = 0; m_b_has = 0; m_op = 0;
                    m_phase = c_P_A;
                end
            end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("cmd_word", cmd_word, m_word());
        check("cmd_valid", cmd_valid, m_phase == c_P_ISSUE);
        check("state", state, m_phase);
        check("err", err, m_err);
        check("cmd_count", cmd_count, m_count);
        @(negedge clk);
    endtask

    task automatic press_digit(input bit [3:0] v);
        digit_btn = 1; digit_val = v; tick(); digit_btn = 0; tick();
    endtask
    task automatic press_op(input bit [1:0] o);
        op_btn = 1; op_val = o; tick(); op_btn = 0; tick();
    endtask
    task automatic press_eq();
        eq_btn = 1; tick(); eq_btn = 0; tick();
    endtask
    task automatic press_clr();
        clr_btn = 1; tick(); clr_btn = 0; tick();
    endtask
    task automatic transfer(input bit [3:0] r);
        cmd_ready = 1; result_in = r; tick(); cmd_ready = 0;
    endtask

    initial begin
        bit [7:0] cnt_before;
        m_clear(1);
        rst_n = 0; digit_btn = 0; op_btn = 0; eq_btn = 0; clr_btn = 0;
        cmd_ready = 0; digit_val = 0; op_val = 0; result_in = 0;
        @(negedge clk);
        tick(); tick();
        check("reset_word", cmd_word, 14'h0000);
        check("reset_state", state, 2'b00);
        rst_n = 1;
        tick();

        // Add 3 + 4, result 7
        press_digit(4'd3); press_op(2'b00); press_digit(4'd4); press_eq();
        check("add_word", cmd_word, 14'b00_0011_0100_0000);
        check("add_valid", cmd_valid, 1'b1);
        transfer(4'd7);
        check("add_count", cmd_count, 8'd1);
        check("add_state", state, 2'b11);
        check("add_valid_off", cmd_valid, 1'b0);

        // Chain off result 7
        press_op(2'b01); press_digit(4'd2); press_eq();
        check("chain_word", cmd_word, 14'b01_0111_0010_0000);
        transfer(4'hA);

        // Unary negate
        press_digit(4'd5);
        op_btn = 1; op_val = 2'b11; tick();
        check("neg_word", cmd_word, 14'b11_0101_0000_0000);
        check("neg_valid", cmd_valid, 1'b1);
        op_btn = 0; tick();
        transfer(4'hB);

        // Illegal keys
        press_clr();
        eq_btn = 1; tick();
        check("ill_eq_err", err, 1'b1);
        check("ill_eq_state", state, 2'b00);
        eq_btn = 0; tick();
        check("ill_eq_err_off", err, 1'b0);
        op_btn = 1; op_val = 2'b00; tick();
        check("ill_op_err", err, 1'b1);
        check("ill_op_state", state, 2'b00);
        op_btn = 0; tick();
        press_digit(4'd1); press_op(2'b11);
        digit_btn = 1; digit_val = 4'd9; tick();
        check("ill_dig_err", err, 1'b1);
        check("ill_dig_word", cmd_word, 14'b11_0001_0000_0000);
        digit_btn = 0; tick();

        // Backpressure then clear racing cmd_ready
        for (int i = 0; i < 10; i++) tick();
        check("bp_word", cmd_word, 14'b11_0001_0000_0000);
        check("bp_valid", cmd_valid, 1'b1);
        cnt_before = m_count;
        clr_btn = 1; cmd_ready = 1; tick();
        check("clr_valid", cmd_valid, 1'b0);
        check("clr_state", state, 2'b00);
        check("clr_count", cmd_count, cnt_before);
        clr_btn = 0; cmd_ready = 0; tick();

        // Priority: digit/op/eq together in S_B with B entered
        press_digit(4'd6); press_op(2'b00); press_digit(4'd7);
        digit_btn = 1; digit_val = 4'd1; op_btn = 1; op_val = 2'b10; eq_btn = 1; tick();
        check("prio_state", state, 2'b10);
        check("prio_word", cmd_word, 14'b00_0110_0111_0000);
        check("prio_err", err, 1'b0);
        digit_btn = 0; op_btn = 0; eq_btn = 0; tick();
        transfer(4'h3);

        // Held button gives one event
        press_clr();
        digit_btn = 1; digit_val = 4'd9; tick();
        digit_val = 4'd2;
        for (int i = 0; i < 19; i++) tick();
        digit_btn = 0; tick();
        press_op(2'b10);
        check("held_word", cmd_word, 14'b10_1001_0000_0000);

        // Reset mid-entry
        press_digit(4'd4);
        rst_n = 0; tick();
        check("rst_count", cmd_count, 8'd0);
        check("rst_word", cmd_word, 14'h0000);
        check("rst_state", state, 2'b00);
        rst_n = 1; tick();

        // Random key traffic
        for (int i = 0; i < 4000; i++) begin
            rst_n     = ($urandom_range(0, 199) != 0);
            digit_btn = ($urandom_range(0, 2) == 0);
            digit_val = 4'($urandom);
            op_btn    = ($urandom_range(0, 3) == 0);
            op_val    = 2'($urandom);
            eq_btn    = ($urandom_range(0, 3) == 0);
            clr_btn   = ($urandom_range(0, 15) == 0);
            cmd_ready = ($urandom_range(0, 2) == 0);
            result_in = 4'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
